// File: rtl/dvp_rgb565_capture_pkg.sv
// Shared types and constants for the DVP RGB565 capture front end:
// FSM state encoding, colour-bar palette and a saturating counter helper.
package dvp_rgb565_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

  // Counters stick at all-ones so an over-long line/frame can never alias to a valid count.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// Registers one sensor sync input, normalises it to active-high and
// reports either its leading (RISE_EDGE=1) or trailing (RISE_EDGE=0) edge.
module dvp_sync_edge #(
  parameter bit POL       = 1'b1,
  parameter bit RISE_EDGE = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_lvl,
  output logic o_edge
);

  logic r_lvl;
  logic r_prev;

  // NOTE: reset is synchronous, so it sits inside the clocked branch; state uses <= so
  // r_prev captures the pre-edge r_lvl rather than the value being written this edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lvl  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_lvl  <= (i_sig == POL);
      r_prev <= r_lvl;
    end
  end

  assign o_lvl  = r_lvl;
  assign o_edge = RISE_EDGE ? (r_lvl & ~r_prev) : (~r_lvl & r_prev);

endmodule

// File: rtl/dvp_rgb565_capture.sv
// DVP camera capture: drops settling frames, packs byte pairs into RGB565 and checks geometry.
// Build option TEST_PATTERN_EN replaces sensor pixels with eight vertical colour bars.
module dvp_rgb565_capture #(
  parameter int unsigned IN_X        = 1280,
  parameter int unsigned IN_Y        = 720,
  parameter int unsigned SKIP_FRAMES = 3,
  parameter bit          VSYNC_POL   = 1'b1
) (
  input  logic        pclk_in,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        vsync_out,
  output logic        href_out,
  output logic        pix_valid,
  output logic [15:0] i_rgb565_out,
  output logic        line_err,
  output logic        frame_err,
  output logic        capturing
);

  import dvp_rgb565_capture_pkg::*;

  localparam logic [15:0] LINE_PIX    = 16'(IN_X);
  localparam logic [15:0] FRAME_LINES = 16'(IN_Y);
  localparam logic [15:0] SKIP_N      = 16'(SKIP_FRAMES);

  logic        w_vs_n;
  logic        w_vs_rise;
  logic        w_href;
  logic        w_href_fall;

  dvp_sync_edge #(.POL(VSYNC_POL), .RISE_EDGE(1'b1)) u_vsync (
    .i_clk  (pclk_in),
    .i_rst  (rst),
    .i_sig  (cam_vsync),
    .o_lvl  (w_vs_n),
    .o_edge (w_vs_rise)
  );

  dvp_sync_edge #(.POL(1'b1), .RISE_EDGE(1'b0)) u_href (
    .i_clk  (pclk_in),
    .i_rst  (rst),
    .i_sig  (cam_href),
    .o_lvl  (w_href),
    .o_edge (w_href_fall)
  );

  cap_state_e  r_state;
  logic [15:0] r_skip_cnt;
  logic [15:0] r_x_cnt;
  logic [15:0] r_y_cnt;
  logic        r_phase;
  logic        r_seen_line;

  logic        w_in_cap;
  logic        w_go_cap;
  logic        w_cap_nxt;
  logic        w_pix_set;
  logic        w_line_bad;
  logic [15:0] w_y_upd;
  logic [15:0] w_pixel;

  assign w_in_cap   = (r_state == ST_CAPTURE);
  assign w_go_cap   = w_vs_rise &
                      (((r_state == ST_IDLE) && (SKIP_N == 16'd0)) ||
                       ((r_state == ST_SKIP) && (r_skip_cnt == SKIP_N)));
  assign w_cap_nxt  = w_in_cap | w_go_cap;
  assign w_pix_set  = w_in_cap & w_href & r_phase;
  // A dangling high byte leaves r_phase set, which alone flags the line as short.
  assign w_line_bad = (r_x_cnt != LINE_PIX) | r_phase;
  // Line that ends on the same cycle as a vsync edge is counted before the frame check.
  assign w_y_upd    = (w_in_cap & w_href_fall) ? sat_inc16(r_y_cnt) : r_y_cnt;

`ifdef TEST_PATTERN_EN
  logic [31:0] w_bar_idx;
  logic [2:0]  w_bar;

  assign w_bar_idx = (32'(r_x_cnt) << 3) / IN_X;
  assign w_bar     = (w_bar_idx > 32'd7) ? 3'd7 : w_bar_idx[2:0];
  assign w_pixel   = bar_color(w_bar);
`else
  logic [7:0] r_data;
  logic [7:0] r_hi;

  always_ff @(posedge pclk_in) begin
    if (rst) begin
      r_data <= 8'd0;
      r_hi   <= 8'd0;
    end else begin
      r_data <= cam_data;
      if (w_in_cap && w_href && !r_phase) begin
        r_hi <= r_data;
      end
    end
  end

  assign w_pixel = {r_hi, r_data};
`endif

  always_ff @(posedge pclk_in) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_skip_cnt   <= 16'd0;
      r_x_cnt      <= 16'd0;
      r_y_cnt      <= 16'd0;
      r_phase      <= 1'b0;
      r_seen_line  <= 1'b0;
      vsync_out    <= 1'b0;
      href_out     <= 1'b0;
      pix_valid    <= 1'b0;
      i_rgb565_out <= 16'd0;
      line_err     <= 1'b0;
      frame_err    <= 1'b0;
      capturing    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_vs_rise) begin
            r_state    <= (SKIP_N == 16'd0) ? ST_CAPTURE : ST_SKIP;
            r_skip_cnt <= 16'd1;
          end
        end
        ST_SKIP: begin
          if (w_vs_rise) begin
            if (r_skip_cnt == SKIP_N) begin
              r_state <= ST_CAPTURE;
            end else begin
              r_skip_cnt <= sat_inc16(r_skip_cnt);
            end
          end
        end
        ST_CAPTURE: r_state <= ST_CAPTURE;
        default:    r_state <= ST_IDLE;
      endcase

      capturing <= w_cap_nxt;
      vsync_out <= w_vs_n & w_cap_nxt;

      r_phase   <= w_in_cap & w_href & ~r_phase;
      pix_valid <= w_pix_set;
      if (w_pix_set) begin
        i_rgb565_out <= w_pixel;
      end

      if (w_pix_set) begin
        href_out <= 1'b1;
      end else if (w_href_fall) begin
        href_out <= 1'b0;
      end

      if (w_href_fall) begin
        r_x_cnt <= 16'd0;
      end else if (w_pix_set) begin
        r_x_cnt <= sat_inc16(r_x_cnt);
      end

      r_y_cnt     <= w_vs_rise ? 16'd0 : w_y_upd;
      r_seen_line <= r_seen_line | (w_in_cap & w_href_fall);

      line_err  <= w_in_cap & w_href_fall & w_line_bad;
      frame_err <= w_in_cap & w_vs_rise & (r_seen_line | w_href_fall) &
                   (w_y_upd != FRAME_LINES);
    end
  end

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Directed bench for dvp_rgb565_capture: one instance with active-high vsync and one
// with active-low vsync fed the inverted sync, both held to the same expected stream.
`timescale 1ns/1ps
module tb_dvp_rgb565_capture;

  localparam int IN_X = 4;
  localparam int IN_Y = 2;
  localparam int SKIP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs;
  logic       href;
  logic [7:0] data;
  logic       vs_inv;

  logic [1:0]  w_vs_out, w_href_out, w_pv, w_le, w_fe, w_cap;
  logic [15:0] w_px [2];

  always #5 clk = ~clk;
  assign vs_inv = ~vs;

  dvp_rgb565_capture #(.IN_X(IN_X), .IN_Y(IN_Y), .SKIP_FRAMES(SKIP), .VSYNC_POL(1'b1)) dut_pos (
    .pclk_in(clk), .rst(rst), .cam_vsync(vs), .cam_href(href), .cam_data(data),
    .vsync_out(w_vs_out[0]), .href_out(w_href_out[0]), .pix_valid(w_pv[0]),
    .i_rgb565_out(w_px[0]), .line_err(w_le[0]), .frame_err(w_fe[0]), .capturing(w_cap[0])
  );

  dvp_rgb565_capture #(.IN_X(IN_X), .IN_Y(IN_Y), .SKIP_FRAMES(SKIP), .VSYNC_POL(1'b0)) dut_neg (
    .pclk_in(clk), .rst(rst), .cam_vsync(vs_inv), .cam_href(href), .cam_data(data),
    .vsync_out(w_vs_out[1]), .href_out(w_href_out[1]), .pix_valid(w_pv[1]),
    .i_rgb565_out(w_px[1]), .line_err(w_le[1]), .frame_err(w_fe[1]), .capturing(w_cap[1])
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] px;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   rd_idx [2] = '{0, 0};
  int   le_cnt [2] = '{0, 0};
  int   fe_cnt [2] = '{0, 0};
  int   vs_cnt [2] = '{0, 0};
  int   le_cyc [2] = '{0, 0};
  int   fe_cyc [2] = '{0, 0};
  int   vs_cyc [2] = '{0, 0};
  logic [1:0] prev_vs_out = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (w_pv[k]) begin
        if (rd_idx[k] < exp_q.size()) begin
          check(k == 0 ? "pix_val_pos" : "pix_val_neg", 32'(w_px[k]), 32'(exp_q[rd_idx[k]].px));
          check(k == 0 ? "pix_cyc_pos" : "pix_cyc_neg", cyc, exp_q[rd_idx[k]].cyc);
          check(k == 0 ? "pix_href_pos" : "pix_href_neg", 32'(w_href_out[k]), 32'd1);
        end else begin
          check(k == 0 ? "pix_extra_pos" : "pix_extra_neg", rd_idx[k], exp_q.size());
        end
        rd_idx[k]++;
      end
      if (w_le[k]) begin le_cnt[k]++; le_cyc[k] = cyc; end
      if (w_fe[k]) begin fe_cnt[k]++; fe_cyc[k] = cyc; end
      if (w_vs_out[k] && !prev_vs_out[k]) begin vs_cnt[k]++; vs_cyc[k] = cyc; end
    end
    prev_vs_out = w_vs_out;
  end

  function automatic logic [15:0] exp_pix(input int j, input logic [7:0] hi, input logic [7:0] lo);
`ifdef TEST_PATTERN_EN
    case ((j * 8) / IN_X)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
`else
    if (j < 0) return 16'h0000;
    return {hi, lo};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic [7:0] d, input logic v);
    href = h;
    data = d;
    vs   = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 8'd0, 1'b0);
      step();
    end
  endtask

  task automatic vsync_pulse(output int v_cyc);
    v_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd0, 1'b1);
      step();
    end
    idle(3);
  endtask

  task automatic send_line(input int nbytes, input bit cap, output int end_cyc);
    for (int i = 0; i < nbytes; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      if (cap && (i % 2 == 1))
        exp_q.push_back({exp_pix(i / 2, 8'(i - 1), 8'(i)), 32'(cyc + 2)});
      step();
    end
    end_cyc = cyc;
    drive(1'b0, 8'd0, 1'b0);
    step();
    idle(3);
  endtask

  task automatic send_frame(input int nlines, input bit cap);
    int v, e;
    vsync_pulse(v);
    idle(2);
    for (int l = 0; l < nlines; l++) send_line(2 * IN_X, cap, e);
  endtask

  task automatic check_both(input string tag, input int got0, input int got1, input int exp);
    check({tag, "_pos"}, got0, exp);
    check({tag, "_neg"}, got1, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v, e, vs_base;
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b0);
    repeat (3) step();
    @(negedge clk);
    check("rst_cap", 32'(w_cap), 32'd0);
    check("rst_pv", 32'(w_pv), 32'd0);
    check("rst_href", 32'(w_href_out), 32'd0);
    check("rst_vsync", 32'(w_vs_out), 32'd0);
    check("rst_px", 32'(w_px[0]), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Two settling frames produce nothing.
    send_frame(IN_Y, 1'b0);
    send_frame(IN_Y, 1'b0);
    check("skip_cap", 32'(w_cap), 32'd0);
    check_both("skip_pix", rd_idx[0], rd_idx[1], 0);
    check_both("skip_vsync", vs_cnt[0], vs_cnt[1], 0);

    // Third frame is captured; vsync_out rises two cycles after vsync is presented.
    vsync_pulse(v);
    check("cap_on", 32'(w_cap), 32'd3);
    check_both("vsync_cnt", vs_cnt[0], vs_cnt[1], 1);
    check_both("vsync_cyc", vs_cyc[0], vs_cyc[1], v + 2);
    idle(2);
    send_line(2 * IN_X, 1'b1, e);
    send_line(2 * IN_X, 1'b1, e);
    check_both("frame3_pix", rd_idx[0], rd_idx[1], 2 * IN_X);
    check("idle_href", 32'(w_href_out), 32'd0);

    // Good frame ends cleanly; then a 7-byte line drops its odd byte and flags line_err.
    vsync_pulse(v);
    check_both("fe_good", fe_cnt[0], fe_cnt[1], 0);
    check_both("le_none", le_cnt[0], le_cnt[1], 0);
    idle(2);
    send_line(2 * IN_X - 1, 1'b1, e);
    check_both("le_short", le_cnt[0], le_cnt[1], 1);
    check_both("le_cyc", le_cyc[0], le_cyc[1], e + 2);
    send_line(2 * IN_X, 1'b1, e);
    check_both("le_after", le_cnt[0], le_cnt[1], 1);

    // Frame of three lines is flagged at the next vsync edge; two-line frames are not.
    vsync_pulse(v);
    check_both("fe_twoline", fe_cnt[0], fe_cnt[1], 0);
    idle(2);
    for (int l = 0; l < 3; l++) send_line(2 * IN_X, 1'b1, e);
    vsync_pulse(v);
    check_both("fe_long", fe_cnt[0], fe_cnt[1], 1);
    check_both("fe_cyc", fe_cyc[0], fe_cyc[1], v + 2);
    idle(2);
    send_line(2 * IN_X, 1'b1, e);
    send_line(2 * IN_X, 1'b1, e);
    vsync_pulse(v);
    check_both("fe_after", fe_cnt[0], fe_cnt[1], 1);
    idle(2);

    // Reset mid-line: one pixel out, then everything clears on the following edge.
    drive(1'b1, 8'd0, 1'b0); step();
    drive(1'b1, 8'd1, 1'b0);
    exp_q.push_back({exp_pix(0, 8'd0, 8'd1), 32'(cyc + 2)});
    step();
    drive(1'b1, 8'd2, 1'b0); step();
    drive(1'b1, 8'd3, 1'b0);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_cap", 32'(w_cap), 32'd0);
    check("mid_rst_pv", 32'(w_pv), 32'd0);
    check("mid_rst_href", 32'(w_href_out), 32'd0);
    check("mid_rst_px", 32'(w_px[0]), 32'd0);
    step();
    drive(1'b0, 8'd0, 1'b0);
    step();
    rst = 1'b0;
    step();
    check_both("mid_rst_pix", rd_idx[0], rd_idx[1], exp_q.size());

    // Restart needs two more skipped frames before capture resumes.
    vs_base = vs_cnt[0];
    send_frame(IN_Y, 1'b0);
    send_frame(IN_Y, 1'b0);
    check("reskip_cap", 32'(w_cap), 32'd0);
    check_both("reskip_vsync", vs_cnt[0], vs_cnt[1], vs_base);
    send_frame(IN_Y, 1'b1);
    check("recap_on", 32'(w_cap), 32'd3);
    check_both("recap_vsync", vs_cnt[0], vs_cnt[1], vs_base + 1);
    vsync_pulse(v);
    check_both("recap_fe", fe_cnt[0], fe_cnt[1], 1);
    check_both("final_le", le_cnt[0], le_cnt[1], 1);
    check_both("final_pix", rd_idx[0], rd_idx[1], exp_q.size());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
